alu_nibble_seq: RTL and testbench

//  Multi-cycle, width-parametrised successor of the combinational CPU ALU.

---
 rtl/alu_nibble_seq.sv | 206 ++++++++++++++++++++
 tb/tb_alu_nibble_seq.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_nibble_seq.sv
// alu_nibble_seq: multi-cycle ALU. Arithmetic ops run one nibble per clock,
// LSB first, with optional per-nibble decimal correction; logic and shift ops
// finish in a single CALC cycle. Start/busy/done handshake, registered outputs.
module alu_nibble_seq #(
  parameter int WIDTH  = 8,
  parameter bit BCD_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [7:0]       flags_i,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y,
  output logic [7:0]       flags_o,
  output logic             p_load
);

  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

  // Bit positions inside the P register image
  localparam int FC = 0;
  localparam int FZ = 1;
  localparam int FD = 3;
  localparam int FH = 5;
  localparam int FV = 6;
  localparam int FN = 7;

  typedef enum logic {IDLE, CALC} state_t;

  state_t           state, state_next;
  logic [CW-1:0]    nib_cnt;
  logic [3:0]       op_r;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [WIDTH-5:0] res_sh;
  logic [7:0]       flags_r;
  logic             carry_r;

  logic             accept, serial_op, sub_op, dec_mode, last, seed;
  logic [3:0]       a_nib, b_nib, r_nib;
  logic [4:0]       raw;
  logic             cout;
  logic [WIDTH-1:0] ser_y, res_y;
  logic [7:0]       res_flags;
  logic             res_pload;

  assign accept = (state == IDLE) && start;
  assign busy   = (state == CALC);

  // Classify the latched op: nibble-serial or not, subtract-style or add-style
  always_comb begin
    serial_op = 1'b0;
    sub_op    = 1'b0;
    case (op_r)
      4'h1, 4'h7, 4'hF: serial_op = 1'b1;
      4'h5, 4'h6, 4'hE: begin
        serial_op = 1'b1;
        sub_op    = 1'b1;
      end
      default: ;
    endcase
    dec_mode = BCD_EN && flags_r[FD] && ((op_r == 4'h1) || (op_r == 4'hE));
    last     = !serial_op || (nib_cnt == CW'(NIB - 1));
  end

  // Carry/borrow seed chosen from the incoming op and P at accept time
  always_comb begin
    case (alu_op)
      4'h1:    seed = flags_i[FC];
      4'hE:    seed = ~flags_i[FC];
      4'hF:    seed = flags_i[FH];
      default: seed = 1'b0;
    endcase
  end

  // One nibble of add/subtract with decimal correction; carry_r holds borrow for sub ops
  always_comb begin
    a_nib = a_sh[3:0];
    b_nib = b_sh[3:0];
    if ((op_r == 4'h6) || (op_r == 4'h7)) begin
      b_nib = (nib_cnt == '0) ? 4'd1 : 4'd0;
    end
    raw   = 5'd0;
    r_nib = 4'd0;
    cout  = 1'b0;
    if (sub_op) begin
      raw   = {1'b0, a_nib} - {1'b0, b_nib} - {4'd0, carry_r};
      cout  = raw[4];
      r_nib = (dec_mode && cout) ? (raw[3:0] - 4'd6) : raw[3:0];
    end else begin
      raw = {1'b0, a_nib} + {1'b0, b_nib} + {4'd0, carry_r};
      if (dec_mode && (raw > 5'd9)) begin
        r_nib = raw[3:0] + 4'd6;
        cout  = 1'b1;
      end else begin
        r_nib = raw[3:0];
        cout  = raw[4];
      end
    end
    ser_y = {r_nib, res_sh};
  end

  // Final result and P image, consumed only on the last CALC cycle
  always_comb begin
    res_y     = a_sh;
    res_flags = flags_r;
    res_pload = (op_r != 4'h0);
    case (op_r)
      4'h1, 4'h5, 4'h6, 4'h7, 4'hE, 4'hF: res_y = ser_y;
      4'h2, 4'h4: res_y = a_sh & b_sh;
      4'h3:       res_y = {a_sh[WIDTH-2:0], 1'b0};
      4'h8:       res_y = a_sh ^ b_sh;
      4'hA:       res_y = {1'b0, a_sh[WIDTH-1:1]};
      4'hB:       res_y = a_sh | b_sh;
      4'hC:       res_y = {a_sh[WIDTH-2:0], flags_r[FC]};
      4'hD:       res_y = {flags_r[FC], a_sh[WIDTH-1:1]};
      default:    res_y = a_sh;
    endcase
    if ((op_r != 4'h0) && (op_r != 4'hF)) begin
      res_flags[FN] = res_y[WIDTH-1];
      res_flags[FZ] = (res_y == '0);
    end
    case (op_r)
      4'h1: begin
        res_flags[FC] = cout;
        res_flags[FV] = (a_nib[3] ^ raw[3]) & (b_nib[3] ^ raw[3]);
      end
      4'h4: begin
        res_flags[FN] = b_sh[WIDTH-1];
        res_flags[FV] = b_sh[WIDTH-2];
      end
      4'h5: res_flags[FC] = ~cout;
      4'hE: begin
        res_flags[FC] = ~cout;
        res_flags[FV] = (a_nib[3] ^ raw[3]) & (~b_nib[3] ^ raw[3]);
      end
      4'hF:       res_flags[FH] = cout;
      4'h3, 4'hC: res_flags[FC] = a_sh[WIDTH-1];
      4'hA, 4'hD: res_flags[FC] = a_sh[0];
      default: ;
    endcase
  end

  // Next-state logic: IDLE waits for start, CALC runs until its last nibble
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CALC;
      CALC:    if (last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Operand latch, nibble shifting and registered result/handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nib_cnt <= '0;
      op_r    <= 4'h0;
      a_sh    <= '0;
      b_sh    <= '0;
      res_sh  <= '0;
      flags_r <= 8'h00;
      carry_r <= 1'b0;
      y       <= '0;
      flags_o <= 8'h00;
      p_load  <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        op_r    <= alu_op;
        a_sh    <= a;
        b_sh    <= b;
        flags_r <= flags_i;
        carry_r <= seed;
        res_sh  <= '0;
        nib_cnt <= '0;
      end else if (state == CALC) begin
        if (last) begin
          y       <= res_y;
          flags_o <= res_flags;
          p_load  <= res_pload;
          done    <= 1'b1;
          nib_cnt <= '0;
        end else begin
          a_sh    <= a_sh >> 4;
          b_sh    <= b_sh >> 4;
          res_sh  <= ser_y[WIDTH-1:4];
          carry_r <= cout;
          nib_cnt <= nib_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_nibble_seq.sv
// tb_alu_nibble_seq: directed and randomized checks of alu_nibble_seq in three
// configurations (8-bit decimal, 8-bit binary-only, 16-bit decimal).
module tb_alu_nibble_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start8 = 1'b0, start8b = 1'b0, start16 = 1'b0;
  logic [3:0]  op = 4'h0;
  logic [7:0]  fl = 8'h00;
  logic [7:0]  a8 = 8'h00, b8 = 8'h00;
  logic [15:0] a16 = 16'h0000, b16 = 16'h0000;

  logic        busy8, done8, p8, busy8b, done8b, p8b, busy16, done16, p16;
  logic [7:0]  y8, y8b, f8, f8b, f16;
  logic [15:0] y16;

  int          sel = 0;
  logic        cur_busy, cur_done, cur_p;
  logic [15:0] cur_y;
  logic [7:0]  cur_f;

  int          checks = 0;
  int          errors = 0;

  logic [15:0] got_y;
  logic [7:0]  got_f;
  logic        got_p, got_busy_first, got_done_after;
  int          got_lat;

  always #5 clk = ~clk;

  alu_nibble_seq #(.WIDTH(8), .BCD_EN(1'b1)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .alu_op(op), .a(a8), .b(b8),
    .flags_i(fl), .busy(busy8), .done(done8), .y(y8), .flags_o(f8), .p_load(p8));

  alu_nibble_seq #(.WIDTH(8), .BCD_EN(1'b0)) dut8b (
    .clk(clk), .rst_n(rst_n), .start(start8b), .alu_op(op), .a(a8), .b(b8),
    .flags_i(fl), .busy(busy8b), .done(done8b), .y(y8b), .flags_o(f8b), .p_load(p8b));

  alu_nibble_seq #(.WIDTH(16), .BCD_EN(1'b1)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .alu_op(op), .a(a16), .b(b16),
    .flags_i(fl), .busy(busy16), .done(done16), .y(y16), .flags_o(f16), .p_load(p16));

  // View of whichever instance is currently under test
  assign cur_busy = (sel == 0) ? busy8 : (sel == 1) ? busy8b : busy16;
  assign cur_done = (sel == 0) ? done8 : (sel == 1) ? done8b : done16;
  assign cur_p    = (sel == 0) ? p8    : (sel == 1) ? p8b    : p16;
  assign cur_f    = (sel == 0) ? f8    : (sel == 1) ? f8b    : f16;
  assign cur_y    = (sel == 0) ? {8'h00, y8} : (sel == 1) ? {8'h00, y8b} : y16;

  // Architectural reference: whole-word arithmetic, nibble loops only for decimal
  function automatic void refModel(input int w, input bit bcd_en, input logic [3:0] opv,
                                   input int av, input int bv, input logic [7:0] fi,
                                   output int ry, output logic [7:0] rf, output logic rp);
    int mask, msb, s, d, cy, bw, an, bn, rawtop, nib;
    bit dec;
    mask = (1 << w) - 1;
    msb  = 1 << (w - 1);
    dec  = bcd_en && fi[3];
    rf   = fi;
    rp   = (opv != 4'h0);
    ry   = av;
    case (opv)
      4'h1: begin
        if (dec) begin
          cy = int'(fi[0]);
          ry = 0;
          rawtop = 0;
          for (int k = 0; k < w / 4; k++) begin
            an = (av >> (4 * k)) & 15;
            bn = (bv >> (4 * k)) & 15;
            s = an + bn + cy;
            rawtop = s;
            if (s > 9) begin s = s + 6; cy = 1; end
            else cy = 0;
            ry = ry | ((s & 15) << (4 * k));
          end
          s = rawtop << (w - 4);
        end else begin
          s  = av + bv + int'(fi[0]);
          ry = s & mask;
          cy = s >> w;
        end
        rf[0] = (cy != 0);
        rf[6] = (((av ^ s) & (bv ^ s) & msb) != 0);
      end
      4'hE: begin
        d = av - bv - (1 - int'(fi[0]));
        rf[0] = (d >= 0);
        rf[6] = (((av ^ d) & (~bv ^ d) & msb) != 0);
        if (dec) begin
          bw = 1 - int'(fi[0]);
          ry = 0;
          for (int k = 0; k < w / 4; k++) begin
            an = (av >> (4 * k)) & 15;
            bn = (bv >> (4 * k)) & 15;
            nib = an - bn - bw;
            if (nib < 0) begin nib = (nib + 16 - 6) & 15; bw = 1; end
            else bw = 0;
            ry = ry | (nib << (4 * k));
          end
        end else begin
          ry = d & mask;
        end
      end
      4'h5: begin d = av - bv; ry = d & mask; rf[0] = (d >= 0); end
      4'h6: ry = (av - 1) & mask;
      4'h7: ry = (av + 1) & mask;
      4'hF: begin s = av + bv + int'(fi[5]); ry = s & mask; rf[5] = ((s >> w) != 0); end
      4'h2, 4'h4: ry = av & bv;
      4'h3: begin ry = (av << 1) & mask; rf[0] = ((av & msb) != 0); end
      4'h8: ry = av ^ bv;
      4'h9: ry = av;
      4'hA: begin ry = av >> 1; rf[0] = ((av & 1) != 0); end
      4'hB: ry = av | bv;
      4'hC: begin ry = ((av << 1) | int'(fi[0])) & mask; rf[0] = ((av & msb) != 0); end
      4'hD: begin ry = (av >> 1) | (fi[0] ? msb : 0); rf[0] = ((av & 1) != 0); end
      default: ry = av;
    endcase
    if ((opv != 4'h0) && (opv != 4'hF)) begin
      rf[7] = ((ry & msb) != 0);
      rf[1] = (ry == 0);
    end
    if (opv == 4'h4) begin
      rf[7] = ((bv & msb) != 0);
      rf[6] = ((bv & (msb >> 1)) != 0);
    end
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Launch one op on the selected instance and wait (bounded) for its done pulse
  task automatic applyStimulus(input int which, input logic [3:0] opv,
                               input logic [15:0] av, input logic [15:0] bv, input logic [7:0] fv);
    @(negedge clk);
    sel = which;
    op = opv; fl = fv;
    a8 = av[7:0]; b8 = bv[7:0]; a16 = av; b16 = bv;
    start8 = (which == 0); start8b = (which == 1); start16 = (which == 2);
    @(negedge clk);
    start8 = 1'b0; start8b = 1'b0; start16 = 1'b0;
    got_busy_first = cur_busy;
    got_lat = 0;
    while (!cur_done && got_lat < 40) begin
      @(negedge clk);
      got_lat++;
    end
    got_y = cur_y;
    got_f = cur_f;
    got_p = cur_p;
    @(negedge clk);
    got_done_after = cur_done;
  endtask

  // Run one op and compare every output against the reference model
  task automatic runCheck(input int which, input logic [3:0] opv, input logic [15:0] av,
                          input logic [15:0] bv, input logic [7:0] fv, input string tag);
    int w, ey, elat;
    logic [7:0] ef;
    logic ep;
    bit bcd;
    w = (which == 2) ? 16 : 8;
    bcd = (which != 1);
    refModel(w, bcd, opv, int'(av) & ((1 << w) - 1), int'(bv) & ((1 << w) - 1), fv, ey, ef, ep);
    elat = (opv inside {4'h1, 4'h5, 4'h6, 4'h7, 4'hE, 4'hF}) ? (w / 4) : 1;
    applyStimulus(which, opv, av, bv, fv);
    checkOutput({tag, "_busy"}, 32'(got_busy_first), 32'd1);
    checkOutput({tag, "_lat"}, 32'(got_lat), 32'(elat));
    checkOutput({tag, "_y"}, 32'(got_y), 32'(ey));
    checkOutput({tag, "_flags"}, 32'(got_f), 32'(ef));
    checkOutput({tag, "_pload"}, 32'(got_p), 32'(ep));
    checkOutput({tag, "_donepulse"}, 32'(got_done_after), 32'd0);
  endtask

  initial begin
    int   seen;
    logic [15:0] ra, rb;
    logic [3:0]  rop;
    logic [7:0]  rfl;

    repeat (3) @(negedge clk);
    sel = 0;
    checkOutput("reset_y", 32'(cur_y), 32'd0);
    checkOutput("reset_flags", 32'(cur_f), 32'd0);
    checkOutput("reset_busy", 32'(cur_busy), 32'd0);
    checkOutput("reset_done", 32'(cur_done), 32'd0);
    checkOutput("reset_pload", 32'(cur_p), 32'd0);
    rst_n = 1'b1;
    $display("[TB] reset released");

    runCheck(0, 4'h1, 16'h45, 16'h38, 8'h08, "adc_bcd");
    checkOutput("adc_bcd_y_const", 32'(got_y), 32'h83);
    checkOutput("adc_bcd_c", 32'(got_f[0]), 32'd0);
    checkOutput("adc_bcd_n", 32'(got_f[7]), 32'd1);
    checkOutput("adc_bcd_lat_const", 32'(got_lat), 32'd2);

    runCheck(0, 4'hE, 16'h50, 16'h01, 8'h09, "sbc_bcd");
    checkOutput("sbc_bcd_y_const", 32'(got_y), 32'h49);
    checkOutput("sbc_bcd_c", 32'(got_f[0]), 32'd1);
    runCheck(1, 4'hE, 16'h50, 16'h01, 8'h09, "sbc_nobcd");
    checkOutput("sbc_nobcd_y_const", 32'(got_y), 32'h4F);

    runCheck(0, 4'h1, 16'h7F, 16'h01, 8'h00, "adc_ovf");
    checkOutput("adc_ovf_flags_const", 32'(got_f), 32'hC0);

    runCheck(0, 4'h5, 16'h10, 16'h20, 8'h40, "cmp");
    checkOutput("cmp_const", {16'h0, got_y[7:0], got_f}, 32'h0000_F0C0);

    runCheck(0, 4'hA, 16'h01, 16'h00, 8'h00, "lsr");
    checkOutput("lsr_flags_const", 32'(got_f), 32'h03);
    runCheck(0, 4'h0, 16'h5A, 16'h33, 8'h81, "op0");
    checkOutput("op0_pload_const", 32'(got_p), 32'd0);

    runCheck(0, 4'h7, 16'hFF, 16'h00, 8'h01, "inc_wrap");
    checkOutput("inc_wrap_const", {16'h0, got_y[7:0], got_f}, 32'h0000_0003);
    runCheck(0, 4'h6, 16'h00, 16'h00, 8'h00, "dec_wrap");
    checkOutput("dec_wrap_const", {16'h0, got_y[7:0], got_f}, 32'h0000_FF80);

    runCheck(2, 4'h1, 16'h00FF, 16'h0001, 8'h00, "adc16");
    checkOutput("adc16_y_const", 32'(got_y), 32'h0100);
    checkOutput("adc16_lat_const", 32'(got_lat), 32'd4);

    // start held through busy and through the done edge
    @(negedge clk);
    sel = 0; op = 4'h1; fl = 8'h00; a8 = 8'h12; b8 = 8'h34; start8 = 1'b1;
    @(negedge clk);
    a8 = 8'h55; b8 = 8'h22;
    @(negedge clk);
    checkOutput("hold_busy_mid", 32'(cur_busy), 32'd1);
    @(negedge clk);
    checkOutput("hold_done", 32'(cur_done), 32'd1);
    checkOutput("hold_first_y", 32'(cur_y), 32'h46);
    checkOutput("hold_busy_at_done", 32'(cur_busy), 32'd0);
    @(negedge clk);
    start8 = 1'b0;
    checkOutput("hold_reaccept_busy", 32'(cur_busy), 32'd1);
    seen = 0;
    while (!cur_done && seen < 40) begin
      @(negedge clk);
      seen++;
    end
    checkOutput("hold_second_lat", 32'(seen), 32'd2);
    checkOutput("hold_second_y", 32'(cur_y), 32'h77);

    // reset in the middle of a 16-bit serial op
    @(negedge clk);
    sel = 2; op = 4'h1; fl = 8'h00; a16 = 16'h1234; b16 = 16'h1111; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    @(negedge clk);
    checkOutput("rst_pre_busy", 32'(cur_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_busy", 32'(cur_busy), 32'd0);
    checkOutput("rst_done", 32'(cur_done), 32'd0);
    checkOutput("rst_y", 32'(cur_y), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (cur_done || cur_busy) seen++;
    end
    checkOutput("rst_no_result", 32'(seen), 32'd0);

    // randomized ops across all three configurations
    for (int i = 0; i < 30; i++) begin
      for (int wsel = 0; wsel < 3; wsel++) begin
        rop = 4'($urandom_range(0, 15));
        ra  = 16'($urandom);
        rb  = 16'($urandom);
        rfl = 8'($urandom);
        runCheck(wsel, rop, ra, rb, rfl, $sformatf("rnd%0d_d%0d_op%0h", i, wsel, rop));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
